// File: rtl/ecc_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// ecc_bus_arbiter_if
// Purpose : bundles the requester-side and link-side handshake buses of
//           ecc_bus_arbiter.
// Signals : req_valid[N_REQ]     per-requester data valid
//           req_data[N_REQ*32]   requester i data in [32*i +: 32]
//           req_ready[N_REQ]     per-requester accept, at most one bit high
//           out_valid            codeword valid
//           out_ready            downstream accept
//           out_data[39]         {data[31:0], ecc[6:0]}
//           out_src[GW]          requester index of the word on out_data
// Modports: slave  - the arbiter
//           master - requesters plus link sink (testbench side)
// ---------------------------------------------------------------------------
interface ecc_bus_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*32-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic                out_valid;
    logic                out_ready;
    logic [38:0]         out_data;
    logic [GW-1:0]       out_src;

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_src
    );

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/ecc_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ecc_bus_arbiter
// Purpose : round-robin scheduler sharing one ECC encode stage between N_REQ
//           32-bit requesters. A grant lasts up to MAX_BURST beats; each
//           accepted word is registered as {data, ecc7(data)} on a single
//           valid/ready link bus.
// Ports   : clk          clock, posedge
//           reset        synchronous, active-high
//           bus          ecc_bus_arbiter_if.slave (requester + link buses)
//           busy         high while the FSM is in BURST
//           beat_count   (ECC_ARB_STATS_EN) link transfers, wrapping
//           rotate_count (ECC_ARB_STATS_EN) BURST->IDLE count, saturating
// Options : `define ECC_ARB_STATS_EN to add the statistics counters/ports.
// ---------------------------------------------------------------------------
module ecc_bus_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                reset,
    ecc_bus_arbiter_if.slave    bus,
    output logic                busy
`ifdef ECC_ARB_STATS_EN
    ,output logic [31:0]        beat_count
    ,output logic [15:0]        rotate_count
`endif
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

    state_t          r_state, w_state_n;
    logic [GW-1:0]   r_grant, w_grant_n;
    logic [GW-1:0]   r_last,  w_last_n;
    logic [CW-1:0]   r_beat_cnt, w_beat_cnt_n;
    logic [GW-1:0]   w_pick;
    logic            w_any;
    logic            w_rdy;
    logic            w_gvalid;
    logic            w_accept;
    logic            w_end;
    logic [31:0]     w_gdata;

    logic            r_out_valid;
    logic [38:0]     r_out_data;
    logic [GW-1:0]   r_out_src;

    function automatic logic [6:0] ecc7(input logic [31:0] d);
        logic [6:0] e;
        e[0] = ^d[31:0];
        e[1] = ^d[15:0];
        e[2] = ^d[7:0];
        e[3] = ^d[3:0];
        e[4] = ^d[1:0];
        e[5] = d[0];
        e[6] = ^{d[31:16], d[7:0]};
        return e;
    endfunction

    // Round-robin pick: scan last+1 .. last+N_REQ. Walking the scan backwards
    // lets the nearest requester after 'last' overwrite the farther ones.
    always_comb begin
        int idx;
        w_pick = '0;
        w_any  = |bus.req_valid;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(r_last) + k) % N_REQ;
            if (bus.req_valid[idx])
                w_pick = GW'(idx);
        end
    end

    assign w_gvalid = bus.req_valid[r_grant];
    assign w_gdata  = bus.req_data[32*int'(r_grant) +: 32];
    // The output register is free when empty or being drained this cycle.
    assign w_rdy    = (r_state == S_BURST) && (!r_out_valid || bus.out_ready);
    assign w_accept = w_rdy && w_gvalid;
    // Burst ends on the last allowed beat, or when the granted requester has
    // nothing to offer while we could take it. A stall never ends a burst.
    assign w_end    = w_rdy && (!w_gvalid || (r_beat_cnt == CW'(MAX_BURST - 1)));

    always_comb begin
        bus.req_ready = '0;
        if (w_rdy)
            bus.req_ready[r_grant] = 1'b1;
    end

    always_comb begin
        w_state_n    = r_state;
        w_grant_n    = r_grant;
        w_last_n     = r_last;
        w_beat_cnt_n = r_beat_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_n    = S_BURST;
                    w_grant_n    = w_pick;
                    w_beat_cnt_n = '0;
                end
            end
            S_BURST: begin
                if (w_accept)
                    w_beat_cnt_n = r_beat_cnt + 1'b1;
                if (w_end) begin
                    w_state_n = S_IDLE;
                    w_last_n  = r_grant;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_last     <= GW'(N_REQ - 1);
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_n;
            r_grant    <= w_grant_n;
            r_last     <= w_last_n;
            r_beat_cnt <= w_beat_cnt_n;
        end
    end

    // Output stage: load on accept (back-to-back allowed), otherwise hold
    // data/src and drop valid once the link takes the word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= {w_gdata, ecc7(w_gdata)};
            r_out_src   <= r_grant;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_src   = r_out_src;
    assign busy          = (r_state == S_BURST);

`ifdef ECC_ARB_STATS_EN
    logic [31:0] r_beat_count;
    logic [15:0] r_rotate_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat_count   <= '0;
            r_rotate_count <= '0;
        end else begin
            if (r_out_valid && bus.out_ready)
                r_beat_count <= r_beat_count + 32'd1;
            if ((r_state == S_BURST) && w_end && (r_rotate_count != 16'hFFFF))
                r_rotate_count <= r_rotate_count + 16'd1;
        end
    end

    assign beat_count   = r_beat_count;
    assign rotate_count = r_rotate_count;
`endif
endmodule

// File: tb/tb_ecc_bus_arbiter.sv
module tb_ecc_bus_arbiter;
    localparam int N = 4;

    typedef struct packed {
        logic [1:0]  src;
        logic [38:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic busy;
`ifdef ECC_ARB_STATS_EN
    logic [31:0] beat_count;
    logic [15:0] rotate_count;
`endif

    ecc_bus_arbiter_if #(.N_REQ(N)) bus ();

    ecc_bus_arbiter #(.N_REQ(N), .MAX_BURST(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .busy         (busy)
`ifdef ECC_ARB_STATS_EN
        ,.beat_count  (beat_count)
        ,.rotate_count(rotate_count)
`endif
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc_n = 0;
    int          cnt_left [N];
    logic [31:0] cur_word [N];
    logic        o_rdy;
    exp_t        sb [$];
    int          acc_src [$];
    int          acc_cyc [$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference encoder written from the parity definitions.
    function automatic logic [38:0] cw(input logic [31:0] d);
        logic [6:0] e;
        e[0] = 1'($countones(d) & 1);
        e[1] = 1'($countones(d[15:0]) & 1);
        e[2] = 1'($countones(d[7:0]) & 1);
        e[3] = 1'($countones(d[3:0]) & 1);
        e[4] = d[1] ^ d[0];
        e[5] = d[0];
        e[6] = 1'(($countones(d[31:16]) + $countones(d[7:0])) & 1);
        return {d, e};
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]         = (cnt_left[i] > 0);
            bus.req_data[32*i +: 32] = cur_word[i];
        end
        bus.out_ready = o_rdy;
    endtask

    // One clock: drive at negedge, resolve handshakes, advance to next negedge.
    task automatic tick();
        bit   renew [N];
        exp_t e;
        drive();
        #1;
        chk("rdy_onehot", 64'($countones(bus.req_ready) <= 1), 64'd1);
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                chk("sb_data", 64'(bus.out_data), 64'(e.data));
                chk("sb_src",  64'(bus.out_src),  64'(e.src));
            end
        end
        for (int i = 0; i < N; i++) begin
            renew[i] = 1'b0;
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                e.src  = 2'(i);
                e.data = cw(cur_word[i]);
                sb.push_back(e);
                acc_src.push_back(i);
                acc_cyc.push_back(cyc_n);
                cnt_left[i]--;
                renew[i] = 1'b1;
            end
        end
        @(posedge clk);
        cyc_n++;
        for (int i = 0; i < N; i++)
            if (renew[i]) cur_word[i] = $urandom();
        @(negedge clk);
    endtask

    task automatic run_until_idle(input string tag);
        bit done;
        for (int n = 0; n < 400; n++) begin
            done = (cnt_left[0] == 0) && (cnt_left[1] == 0) && (cnt_left[2] == 0) &&
                   (cnt_left[3] == 0) && (sb.size() == 0) && !bus.out_valid && !busy;
            if (done) break;
            tick();
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    task automatic wait_accepts(input int target);
        for (int n = 0; n < 40 && acc_src.size() < target; n++) tick();
        chk("wait_acc", 64'(acc_src.size() >= target), 64'd1);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        for (int i = 0; i < N; i++) cnt_left[i] = 0;
        o_rdy = 1'b1;
        drive();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int           base;
        logic [38:0]  d0;
        logic [1:0]   s0;
        for (int i = 0; i < N; i++) cur_word[i] = $urandom();

        // Reset values
        apply_reset();
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data",  64'(bus.out_data),  64'd0);
        chk("rst_out_src",   64'(bus.out_src),   64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_busy",      64'(busy),          64'd0);
        @(negedge clk);

        // Single beat, data 1 -> codeword {1, 7'h7F}
        cnt_left[0] = 1;
        cur_word[0] = 32'h0000_0001;
        drive(); #1;
        chk("sb1_idle_busy", 64'(busy), 64'd0);
        chk("sb1_idle_rdy",  64'(bus.req_ready), 64'd0);
        tick();
        drive(); #1;
        chk("sb1_burst_busy", 64'(busy), 64'd1);
        chk("sb1_burst_rdy",  64'(bus.req_ready), 64'b0001);
        tick();
        drive(); #1;
        chk("sb1_out_valid", 64'(bus.out_valid), 64'd1);
        chk("sb1_out_data",  64'(bus.out_data),  64'h00_0000_00FF);
        chk("sb1_out_src",   64'(bus.out_src),   64'd0);
        run_until_idle("sb1_drain");

        // Round-robin with all requesters valid, fresh priority
        apply_reset();
        base = acc_src.size();
        cnt_left[0] = 8; cnt_left[1] = 4; cnt_left[2] = 4; cnt_left[3] = 4;
        run_until_idle("rr_drain");
        chk("rr_count", 64'(acc_src.size() - base), 64'd20);
        if (acc_src.size() - base >= 20)
            for (int k = 0; k < 20; k++) begin
                chk("rr_src", 64'(acc_src[base+k]), 64'((k / 4) % 4));
                chk("rr_cyc", 64'(acc_cyc[base+k] - acc_cyc[base]), 64'(k + k / 4));
            end

        // Backpressure: 5 stalled cycles after 2 beats of requester 1
        base = acc_src.size();
        cnt_left[1] = 4;
        wait_accepts(base + 2);
        o_rdy = 1'b0;
        drive(); #1;
        d0 = bus.out_data;
        s0 = bus.out_src;
        for (int n = 0; n < 5; n++) begin
            drive(); #1;
            chk("bp_rdy",   64'(bus.req_ready), 64'd0);
            chk("bp_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_data",  64'(bus.out_data),  64'(d0));
            chk("bp_src",   64'(bus.out_src),   64'(s0));
            tick();
        end
        o_rdy = 1'b1;
        run_until_idle("bp_drain");
        chk("bp_count", 64'(acc_src.size() - base), 64'd4);
        if (acc_src.size() - base >= 4) begin
            chk("bp_gap",  64'(acc_cyc[base+2] - acc_cyc[base+1]), 64'd6);
            chk("bp_cont", 64'(acc_cyc[base+3] - acc_cyc[base+2]), 64'd1);
            for (int k = 0; k < 4; k++) chk("bp_src_seq", 64'(acc_src[base+k]), 64'd1);
        end

        // Early drain: requester 2 stops after 2 beats, requester 3 follows
        base = acc_src.size();
        cnt_left[2] = 2; cnt_left[3] = 2;
        run_until_idle("ed_drain");
        chk("ed_count", 64'(acc_src.size() - base), 64'd4);
        if (acc_src.size() - base >= 4) begin
            chk("ed_src0", 64'(acc_src[base+0]), 64'd2);
            chk("ed_src1", 64'(acc_src[base+1]), 64'd2);
            chk("ed_src2", 64'(acc_src[base+2]), 64'd3);
            chk("ed_src3", 64'(acc_src[base+3]), 64'd3);
            chk("ed_cyc2", 64'(acc_cyc[base+2] - acc_cyc[base]), 64'd4);
            chk("ed_cyc3", 64'(acc_cyc[base+3] - acc_cyc[base]), 64'd5);
        end

        // Reset mid-burst; pending output word is discarded
        base = acc_src.size();
        cnt_left[2] = 6;
        wait_accepts(base + 2);
        cnt_left[2] = 0;
        o_rdy = 1'b0;
        drive();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc_n++;
        #1;
        chk("mr_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mr_busy",      64'(busy),          64'd0);
        chk("mr_req_ready", 64'(bus.req_ready), 64'd0);
        sb.delete();
        o_rdy = 1'b1;
        @(negedge clk);

        // 10 beats over 3 grants after the reset: requester 0 first
        base = acc_src.size();
        cnt_left[0] = 4; cnt_left[1] = 4; cnt_left[2] = 2;
        run_until_idle("st_drain");
        chk("st_count", 64'(acc_src.size() - base), 64'd10);
        if (acc_src.size() - base >= 10)
            for (int k = 0; k < 10; k++)
                chk("st_src", 64'(acc_src[base+k]), 64'(k / 4));
`ifdef ECC_ARB_STATS_EN
        chk("st_beat_count",   64'(beat_count),   64'd10);
        chk("st_rotate_count", 64'(rotate_count), 64'd3);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
